wptr_ctrl: RTL and testbench

Write-side pointer controller for the gray-coded pointer crossing. Runs in the write clock domain and owns the binary write count. It publishes that count as a registered gray pointer for the read-side synchronizer, and gates incoming pushes against full using the already-synchronized read pointer. It also sequences a drain/flush handshake, so upstream logic can quiesce the crossing before reconfiguration.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/wptr_ctrl_if.sv | 31 +++
 rtl/gray2bin.sv | 16 +
 rtl/wptr_ctrl.sv | 102 ++++++++++
 tb/tb_wptr_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and gray-code helpers for the pointer-crossing blocks.
// Helpers work on zero-extended 32-bit values, so any pointer width up to 32 can use them.
package gray_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wptr_state_t;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray_f(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin_f(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_ctrl_if.sv
// Push handshake and memory write port of the write-side pointer controller.
// A push transfers on a cycle where i_push && o_ready; o_wen/o_waddr describe that transfer in the same cycle.
interface wptr_ctrl_if
    import gray_pkg::*;
#(
    parameter int ADDR_W = 4
) ();

    logic              i_push;
    logic              o_ready;
    logic              o_wen;
    logic [ADDR_W-1:0] o_waddr;
    wptr_state_t       dbg_state;

    modport master (
        output i_push,
        input  o_ready,
        input  o_wen,
        input  o_waddr,
        input  dbg_state
    );

    modport slave (
        input  i_push,
        output o_ready,
        output o_wen,
        output o_waddr,
        output dbg_state
    );

endinterface

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of the gray bits at and above it.
module gray2bin #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < SIZE; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_ctrl.sv
// Write-domain pointer controller: owns wbin, publishes a registered gray pointer, gates pushes on full, sequences drain.
// Define WPTR_CTRL_OVF_EN to build the sticky push-while-full flag; otherwise o_overflow is tied low.
module wptr_ctrl
    import gray_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic              wclk,
    input  logic              wrst,
    wptr_ctrl_if.slave        wif,
    input  logic [ADDR_W:0]   i_rptr_gray,
    input  logic              i_flush_req,
    output logic [ADDR_W:0]   o_wcount,
    output logic [ADDR_W:0]   o_wptr_gray,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_flush_done,
    output logic              o_overflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);

    wptr_state_t      state;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_nxt;
    logic [PTR_W-1:0] wgray;
    logic [PTR_W-1:0] rbin;
    logic             flush_done_q;
    logic             push_ok;

    gray2bin #(.SIZE(PTR_W)) u_rptr_g2b (
        .gray (i_rptr_gray),
        .bin  (rbin)
    );

    assign wbin_nxt = wbin + PTR_W'(1);

    // Full when the write pointer is exactly one lap ahead: top two gray bits inverted, the rest equal.
    assign o_full        = (wgray == {~i_rptr_gray[ADDR_W:ADDR_W-1], i_rptr_gray[ADDR_W-2:0]});
    assign o_level       = wbin - rbin;
    assign o_almost_full = (o_level >= AF_LEVEL);

    assign wif.o_ready   = !wrst && (state == RUN) && !o_full;
    assign push_ok       = wif.i_push && wif.o_ready;
    assign wif.o_wen     = push_ok;
    assign wif.o_waddr   = wbin[ADDR_W-1:0];
    assign wif.dbg_state = state;

    assign o_wcount      = wbin;
    assign o_wptr_gray   = wgray;
    assign o_flush_done  = flush_done_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state        <= RUN;
            wbin         <= '0;
            wgray        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (push_ok) begin
                wbin  <= wbin_nxt;
                wgray <= PTR_W'(bin2gray_f(GRAY_MAX_W'(wbin_nxt)));
            end
            case (state)
                RUN: begin
                    if (i_flush_req) state <= DRAIN;
                end
                DRAIN: begin
                    // Reader has consumed everything written: the crossing is empty.
                    if (i_rptr_gray == wgray) begin
                        flush_done_q <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef WPTR_CTRL_OVF_EN
    logic ovf_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            ovf_q <= 1'b0;
        end else if ((state == RUN) && o_full && wif.i_push) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_overflow = ovf_q;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_ctrl.sv
// Self-checking bench for wptr_ctrl (ADDR_W=4, AF_MARGIN=2): directed scenarios plus a random phase.
module tb_wptr_ctrl;
    import gray_pkg::*;

    localparam int AW = 4;
    localparam int PW = AW + 1;

    // clock / reset
    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    wptr_ctrl_if #(.ADDR_W(AW)) wif ();
    logic [PW-1:0] i_rptr_gray;
    logic          i_flush_req;
    logic [PW-1:0] o_wcount;
    logic [PW-1:0] o_wptr_gray;
    logic [PW-1:0] o_level;
    logic          o_full;
    logic          o_almost_full;
    logic          o_flush_done;
    logic          o_overflow;

    wptr_ctrl #(.ADDR_W(AW), .AF_MARGIN(2)) dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .wif           (wif),
        .i_rptr_gray   (i_rptr_gray),
        .i_flush_req   (i_flush_req),
        .o_wcount      (o_wcount),
        .o_wptr_gray   (o_wptr_gray),
        .o_level       (o_level),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_flush_done  (o_flush_done),
        .o_overflow    (o_overflow)
    );

    // scoreboard and reference model
    int            n_cmp;
    int            n_err;
    logic [AW-1:0] exp_q[$];
    int            m_state;
    logic [PW-1:0] m_wbin;
    logic [PW-1:0] m_rbin;
    logic          m_done;
    logic          m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return b ^ {1'b0, b[PW-1:1]};
    endfunction

    function automatic logic [PW-1:0] lvl_f();
        return m_wbin - m_rbin;
    endfunction

    always @(negedge wclk) begin
        if (!wrst && wif.o_wen) begin
            if (exp_q.size() == 0) check("sb_empty", exp_q.size(), 1);
            else                   check("waddr", wif.o_waddr, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic do_reset();
        wrst            = 1'b1;
        wif.i_push      = 1'b0;
        i_flush_req     = 1'b0;
        m_rbin          = '0;
        i_rptr_gray     = '0;
        @(posedge wclk); #1;
        check("rst_ready", wif.o_ready, 0);
        check("rst_wcount", o_wcount, 0);
        check("rst_gray", o_wptr_gray, 0);
        check("rst_level", o_level, 0);
        check("rst_full", o_full, 0);
        check("rst_afull", o_almost_full, 0);
        check("rst_fdone", o_flush_done, 0);
        check("rst_ovf", o_overflow, 0);
        wrst    = 1'b0;
        m_state = 0;
        m_wbin  = '0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic drive(input logic push, input logic flush);
        logic [PW-1:0] rg;
        logic [PW-1:0] lvl;
        logic          full;
        logic          rdy;
        logic          acc;
        rg          = b2g(m_rbin);
        wif.i_push  = push;
        i_rptr_gray = rg;
        i_flush_req = flush;
        #1;
        lvl  = lvl_f();
        full = (lvl == PW'(16));
        rdy  = (m_state == 0) && !full;
        acc  = push && rdy;
        check("state", wif.dbg_state, m_state);
        check("wcount", o_wcount, m_wbin);
        check("wgray", o_wptr_gray, b2g(m_wbin));
        check("level", o_level, lvl);
        check("full", o_full, full);
        check("afull", o_almost_full, lvl >= PW'(14));
        check("ready", wif.o_ready, rdy);
        check("wen", wif.o_wen, acc);
        check("fdone", o_flush_done, m_done);
        check("ovf", o_overflow, m_ovf);
        if (acc) exp_q.push_back(m_wbin[AW-1:0]);
`ifdef WPTR_CTRL_OVF_EN
        if (push && (m_state == 0) && full) m_ovf = 1'b1;
`endif
        m_done = 1'b0;
        case (m_state)
            0: if (flush) m_state = 1;
            1: if (rg == b2g(m_wbin)) begin m_done = 1'b1; m_state = 2; end
            default: m_state = 0;
        endcase
        if (acc) m_wbin = m_wbin + PW'(1);
        @(posedge wclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        wrst = 1'b1; wif.i_push = 1'b0; i_rptr_gray = '0; i_flush_req = 1'b0;
        m_state = 0; m_wbin = '0; m_rbin = '0; m_done = 1'b0; m_ovf = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        do_reset();

        // fill to full, then a 17th push that must be dropped
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0);
        check("fill_gray", o_wptr_gray, 5'b11000);
        check("fill_full", o_full, 1);
        check("fill_ready", wif.o_ready, 0);
        drive(1'b1, 1'b0);
        check("hold_wcount", o_wcount, 16);

        // release from full with the same-cycle push
        m_rbin = 5'd1;
        drive(1'b1, 1'b0);
        check("rel_wcount", o_wcount, 17);

        // pointer wrap with the reader trailing
        for (int k = 0; k < 40 && m_wbin != 5'd31; k++) begin
            if (lvl_f() > PW'(3)) m_rbin = m_rbin + PW'(1);
            drive(1'b1, 1'b0);
        end
        check("prewrap_gray", o_wptr_gray, 5'b10000);
        m_rbin = m_rbin + PW'(1);
        drive(1'b1, 1'b0);
        check("wrap_wcount", o_wcount, 0);
        check("wrap_gray", o_wptr_gray, 5'b00000);
        check("wrap_level", o_level, lvl_f());

        // flush at level 3; pushes and repeat requests ignored while draining
        m_rbin = m_wbin - PW'(3);
        drive(1'b0, 1'b1);
        check("flush_ready", wif.o_ready, 0);
        drive(1'b1, 1'b1);
        m_rbin = m_rbin + PW'(1); drive(1'b1, 1'b0);
        m_rbin = m_rbin + PW'(1); drive(1'b0, 1'b0);
        m_rbin = m_rbin + PW'(1); drive(1'b1, 1'b0);
        check("flush_pulse", o_flush_done, 1);
        drive(1'b1, 1'b0);
        check("flush_once", o_flush_done, 0);
        drive(1'b1, 1'b0);

        // overflow
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0);
        check("ovf_pre", o_overflow, 0);
        drive(1'b1, 1'b0);
`ifdef WPTR_CTRL_OVF_EN
        check("ovf_set", o_overflow, 1);
`else
        check("ovf_tied", o_overflow, 0);
`endif
        check("ovf_wcount", o_wcount, 16);
        drive(1'b0, 1'b0);
        check("ovf_gray", o_wptr_gray, 5'b11000);

        // reset mid-DRAIN
        m_rbin = 5'd2;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        check("rmd_in_drain", wif.dbg_state, DRAIN);
        do_reset();
        check("rmd_state", wif.dbg_state, RUN);
        drive(1'b0, 1'b0);
        check("rmd_fdone", o_flush_done, 0);

        // random traffic
        for (int c = 0; c < 300; c++) begin
            if (m_rbin != m_wbin && $urandom_range(0, 2) == 0) m_rbin = m_rbin + PW'(1);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        wif.i_push = 1'b0;
        @(negedge wclk);
        check("sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
